// File: rtl/row_sweeper.sv
// Moving-row engine for a stacker game: sweeps a lit row across the playfield,
// locks it on stop, and lands it on the surviving stack below.
module row_sweeper #(
  parameter int COLS  = 8,
  parameter int CNT_W = 26,
  parameter int LVL_W = 4,
  parameter int W_W   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             stop_btn,
  input  logic [CNT_W-1:0] speed_count,
  input  logic [W_W-1:0]   num_blocks,
  input  logic [LVL_W-1:0] curr_level,
  output logic [COLS-1:0]  row_mask,
  output logic [COLS-1:0]  stacked_mask,
  output logic [W_W-1:0]   surviving,
  output logic             busy,
  output logic             next_signal,
  output logic             fail_signal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2,
    S_JUDGE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_spd;
  logic [CNT_W-1:0] r_tick;
  logic             r_dir;
  logic [COLS-1:0]  r_row;
  logic [COLS-1:0]  r_stack;
  logic [COLS-1:0]  r_land;
  logic [W_W-1:0]   r_surv;
  logic             r_busy;
  logic             r_next;
  logic             r_fail;

  logic [CNT_W-1:0] w_spd;
  logic [W_W-1:0]   w_width;
  logic [COLS-1:0]  w_init;
  logic [COLS-1:0]  w_stepped;
  logic             w_dir_n;
  logic [COLS-1:0]  w_land;

  function automatic logic [W_W-1:0] popcount(input logic [COLS-1:0] m);
    logic [W_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < COLS; i++) begin
      cnt = cnt + {{(W_W-1){1'b0}}, m[i]};
    end
    return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_LOAD; else w_next = S_IDLE;
      S_LOAD:  w_next = S_SWEEP;
      S_SWEEP: if (stop_btn) w_next = S_JUDGE; else w_next = S_SWEEP;
      S_JUDGE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch values and next-position computation; a full-width row pins both ends and stays put.
  always_comb begin
    w_spd = (speed_count == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : speed_count;
    if (num_blocks == '0) begin
      w_width = {{(W_W-1){1'b0}}, 1'b1};
    end else if (num_blocks > W_W'(COLS)) begin
      w_width = W_W'(COLS);
    end else begin
      w_width = num_blocks;
    end
    w_init    = ~({COLS{1'b1}} << w_width);
    w_stepped = r_row;
    w_dir_n   = r_dir;
    if (r_row[COLS-1] && r_row[0]) begin
      w_stepped = r_row;
      w_dir_n   = r_dir;
    end else if (!r_dir) begin
      if (r_row[COLS-1]) begin
        w_stepped = r_row >> 1;
        w_dir_n   = 1'b1;
      end else begin
        w_stepped = r_row << 1;
        w_dir_n   = 1'b0;
      end
    end else begin
      if (r_row[0]) begin
        w_stepped = r_row << 1;
        w_dir_n   = 1'b0;
      end else begin
        w_stepped = r_row >> 1;
        w_dir_n   = 1'b1;
      end
    end
    w_land = (curr_level == LVL_W'(1)) ? r_row : (r_row & r_stack);
  end

  // Datapath: land is captured on the stop edge so the pulse appears in JUDGE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_spd   <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_tick  <= '0;
      r_dir   <= 1'b0;
      r_row   <= '0;
      r_stack <= '1;
      r_land  <= '0;
      r_surv  <= W_W'(COLS);
      r_busy  <= 1'b0;
      r_next  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_next <= 1'b0;
      r_fail <= 1'b0;
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_LOAD: begin
          r_spd  <= w_spd;
          r_row  <= w_init;
          r_dir  <= 1'b0;
          r_tick <= '0;
        end
        S_SWEEP: begin
          if (stop_btn) begin
            r_land <= w_land;
            r_next <= |w_land;
            r_fail <= ~|w_land;
          end else if (r_tick == r_spd - CNT_W'(1)) begin
            r_tick <= '0;
            r_row  <= w_stepped;
            r_dir  <= w_dir_n;
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        S_JUDGE: begin
          if (|r_land) begin
            r_stack <= r_land;
            r_surv  <= popcount(r_land);
          end else begin
            r_stack <= '1;
            r_surv  <= W_W'(COLS);
          end
          r_row <= '0;
        end
        default: begin
          r_row <= r_row;
        end
      endcase
    end
  end

  assign row_mask     = r_row;
  assign stacked_mask = r_stack;
  assign surviving    = r_surv;
  assign busy         = r_busy;
  assign next_signal  = r_next;
  assign fail_signal  = r_fail;

endmodule

// File: tb/tb_row_sweeper.sv
// Self-checking bench for row_sweeper: directed levels plus randomized levels,
// checked against a triangle-wave position model of the sweeping row.
module tb_row_sweeper;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic        stop_btn = 1'b0;
  logic [25:0] speed_count = '0;
  logic [3:0]  num_blocks = '0;
  logic [3:0]  curr_level = '0;
  logic [7:0]  row_mask;
  logic [7:0]  stacked_mask;
  logic [3:0]  surviving;
  logic        busy;
  logic        next_signal;
  logic        fail_signal;

  int total = 0;
  int bad = 0;
  logic [7:0] m_stack = 8'hFF;

  row_sweeper dut (
    .clk(clk), .resetn(resetn), .go(go), .stop_btn(stop_btn),
    .speed_count(speed_count), .num_blocks(num_blocks), .curr_level(curr_level),
    .row_mask(row_mask), .stacked_mask(stacked_mask), .surviving(surviving),
    .busy(busy), .next_signal(next_signal), .fail_signal(fail_signal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Row after c sweep cycles: position is a triangle wave over 0..COLS-w.
  function automatic logic [7:0] exp_row(input int spd, input int nb, input int c);
    int s, w, k, r, t, pos;
    logic [15:0] m;
    s = (spd == 0) ? 1 : spd;
    w = (nb < 1) ? 1 : ((nb > 8) ? 8 : nb);
    k = c / s;
    r = 8 - w;
    if (r == 0) pos = 0;
    else begin
      t = k % (2 * r);
      pos = (t <= r) ? t : 2 * r - t;
    end
    m = ((16'd1 << w) - 16'd1) << pos;
    return m[7:0];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_row"}, 32'(row_mask), 32'h0);
    chk({tag, "_stack"}, 32'(stacked_mask), 32'(m_stack));
    chk({tag, "_surv"}, 32'(surviving), 32'($countones(m_stack)));
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_pulses"}, {30'h0, next_signal, fail_signal}, 32'h0);
  endtask

  task automatic run_level(input int spd, input int nb, input int lvl,
                           input int stop_after, input int reset_at, input bit mid_go);
    logic [7:0] row_e, land;
    speed_count = 26'(spd);
    num_blocks  = 4'(nb);
    curr_level  = 4'(lvl);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("load_busy", 32'(busy), 32'h1);
    tick();
    for (int c = 0; c < stop_after; c++) begin
      chk("sweep_row", 32'(row_mask), 32'(exp_row(spd, nb, c)));
      chk("sweep_busy", 32'(busy), 32'h1);
      if (c == reset_at) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        m_stack = 8'hFF;
        chk_idle("midreset");
        tick();
        chk_idle("post_reset_idle");
        return;
      end
      go = (mid_go && c == 1);
      speed_count = 26'($urandom);
      num_blocks  = 4'($urandom);
      tick();
      go = 1'b0;
    end
    row_e = exp_row(spd, nb, stop_after);
    chk("prestop_row", 32'(row_mask), 32'(row_e));
    stop_btn = 1'b1;
    tick();
    stop_btn = 1'b0;
    land = (lvl == 1) ? row_e : (row_e & m_stack);
    chk("judge_row", 32'(row_mask), 32'(row_e));
    chk("judge_busy", 32'(busy), 32'h1);
    chk("judge_next", 32'(next_signal), 32'(land != 8'h0));
    chk("judge_fail", 32'(fail_signal), 32'(land == 8'h0));
    m_stack = (land != 8'h0) ? land : 8'hFF;
    tick();
    chk_idle("after_judge");
  endtask

  initial begin
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk_idle("reset");
    // Full bounce sequence observed, then lands on the ground row.
    run_level(3, 3, 1, 20, -1, 1'b0);
    // Stop at 0x1C on ground.
    run_level(3, 3, 1, 6, -1, 1'b0);
    chk("t2_stack", 32'(stacked_mask), 32'h1C);
    chk("t2_surv", 32'(surviving), 32'h3);
    // 0x38 over 0x1C.
    run_level(3, 3, 2, 9, -1, 1'b0);
    chk("t3_stack", 32'(stacked_mask), 32'h18);
    chk("t3_surv", 32'(surviving), 32'h2);
    // 0x07 over 0x18 misses.
    run_level(3, 3, 3, 0, -1, 1'b0);
    chk("t4_stack", 32'(stacked_mask), 32'hFF);
    chk("t4_surv", 32'(surviving), 32'h8);
    // Edges: stop coinciding with a step, spd=0, nb=0, nb=9.
    run_level(4, 2, 1, 7, -1, 1'b0);
    run_level(0, 0, 2, 10, -1, 1'b0);
    run_level(2, 9, 2, 7, -1, 1'b0);
    chk("nb9_stack", 32'(stacked_mask), 32'(m_stack));
    // go mid-sweep ignored, then reset mid-sweep.
    run_level(2, 4, 2, 12, -1, 1'b1);
    run_level(3, 3, 2, 10, 5, 1'b1);
    for (int i = 0; i < 12; i++) begin
      run_level(int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
                int'($urandom_range(1, 4)), int'($urandom_range(0, 30)), -1,
                1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
